// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Purpose:
//    Control FSM for a multi-cycle RV32I datapath. Steps each instruction
//    through FETCH, DECODE, EXECUTE, optional MEM and optional WB. It owns the
//    instruction/data memory req/ack handshakes with timeout detection, and a
//    TRAP state that is left only through i_trap_clr.
//
// Parameters:
//    TIMEOUT_CYCLES : wait cycles allowed for an ack before trapping (1..255)
//    TO_W           : width of the timeout counter (>= clog2(TIMEOUT_CYCLES+1))
//
// Ports:
//    i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//    i_run                 1 = keep executing, 0 = halt after current instr
//    o_imem_req/i_imem_ack instruction fetch handshake
//    o_ir_write            load instruction register (same cycle as imem ack)
//    i_branch_enable, i_mem_write_enable, i_reg_write_enable, i_mem_to_reg,
//    i_ill_instr           decoded control bits, held from DECODE to retire
//    i_alu_zero            ALU result == 0, selects branch target
//    o_dmem_req/o_dmem_we/i_dmem_ack  data memory handshake
//    o_reg_write           register-file write strobe
//    o_pc_write, o_pc_sel_branch      PC update and target select
//    o_retire              one-cycle pulse per completed instruction
//    o_halted              sequencer is idle
//    o_trap, o_trap_cause  trap flag and cause (01 imem, 10 illegal, 11 dmem)
//    i_trap_clr            leaves TRAP
//
// Optional feature (macro SEQ_PERF_CNT_EN):
//    Adds o_cycle_count (cycles spent outside IDLE and TRAP) and
//    o_instret_count (retired instructions). Both 32 bits, wrapping.
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int TO_W           = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_run,
   output logic       o_imem_req,
   input  logic       i_imem_ack,
   output logic       o_ir_write,
   input  logic       i_branch_enable,
   input  logic       i_mem_write_enable,
   input  logic       i_reg_write_enable,
   input  logic       i_mem_to_reg,
   input  logic       i_ill_instr,
   input  logic       i_alu_zero,
   output logic       o_dmem_req,
   output logic       o_dmem_we,
   input  logic       i_dmem_ack,
   output logic       o_reg_write,
   output logic       o_pc_write,
   output logic       o_pc_sel_branch,
   output logic       o_retire,
   output logic       o_halted,
   output logic       o_trap,
   output logic [1:0] o_trap_cause,
   input  logic       i_trap_clr
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] o_cycle_count,
   output logic [31:0] o_instret_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_TRAP    = 3'd6
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_IMEM = 2'b01;
   localparam logic [1:0] CAUSE_ILL  = 2'b10;
   localparam logic [1:0] CAUSE_DMEM = 2'b11;

   // The counter holds the number of ack-less cycles already spent in the
   // current wait state, so the TIMEOUT_CYCLES-th cycle sees TIMEOUT_CYCLES-1.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   logic [TO_W-1:0] r_to_cnt;
   logic [1:0]      r_trap_cause;
   logic            w_to_expired;
   logic            w_mem_op;

   assign w_to_expired = (r_to_cnt == TO_LAST);
   assign w_mem_op     = i_mem_write_enable | i_mem_to_reg;

   // -------------------------------------------------------------------------
   // State, timeout counter and trap cause. The counter is cleared by default
   // and only advances while staying in a wait state, so every state change
   // clears it.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_to_cnt     <= '0;
         r_trap_cause <= CAUSE_NONE;
      end else begin
         r_to_cnt <= '0;
         case (r_state)
            S_IDLE: begin
               if (i_run) r_state <= S_FETCH;
            end
            S_FETCH: begin
               // An ack in the last allowed cycle wins over the timeout.
               if (i_imem_ack) begin
                  r_state <= S_DECODE;
               end else if (w_to_expired) begin
                  r_state      <= S_TRAP;
                  r_trap_cause <= CAUSE_IMEM;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (i_ill_instr) begin
                  r_state      <= S_TRAP;
                  r_trap_cause <= CAUSE_ILL;
               end else begin
                  r_state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (i_branch_enable)         r_state <= i_run ? S_FETCH : S_IDLE;
               else if (w_mem_op)           r_state <= S_MEM;
               else if (i_reg_write_enable) r_state <= S_WB;
               else                         r_state <= i_run ? S_FETCH : S_IDLE;
            end
            S_MEM: begin
               if (i_dmem_ack) begin
                  if (i_mem_to_reg) r_state <= S_WB;
                  else              r_state <= i_run ? S_FETCH : S_IDLE;
               end else if (w_to_expired) begin
                  r_state      <= S_TRAP;
                  r_trap_cause <= CAUSE_DMEM;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_WB: begin
               r_state <= i_run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
               if (i_trap_clr) begin
                  r_state      <= S_IDLE;
                  r_trap_cause <= CAUSE_NONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Moore outputs, decoded straight from the state so reset removes the
   // memory requests immediately.
   // -------------------------------------------------------------------------
   assign o_imem_req   = (r_state == S_FETCH);
   assign o_dmem_req   = (r_state == S_MEM);
   assign o_dmem_we    = (r_state == S_MEM) & i_mem_write_enable;
   assign o_halted     = (r_state == S_IDLE);
   assign o_trap       = (r_state == S_TRAP);
   assign o_trap_cause = r_trap_cause;

   // -------------------------------------------------------------------------
   // Mealy strobes. They depend on the ack/decoder inputs of the current
   // cycle so the datapath commits in the same cycle the FSM moves on.
   // -------------------------------------------------------------------------
   always_comb begin
      o_ir_write      = 1'b0;
      o_pc_write      = 1'b0;
      o_pc_sel_branch = 1'b0;
      o_reg_write     = 1'b0;
      o_retire        = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_ir_write = i_imem_ack;
         end
         S_EXECUTE: begin
            if (i_branch_enable) begin
               o_pc_write      = 1'b1;
               o_pc_sel_branch = i_alu_zero;
               o_retire        = 1'b1;
            end else if (!w_mem_op && !i_reg_write_enable) begin
               o_pc_write = 1'b1;
               o_retire   = 1'b1;
            end
         end
         S_MEM: begin
            // Stores complete here; loads still have a WB cycle to go.
            if (i_dmem_ack && !i_mem_to_reg) begin
               o_pc_write = 1'b1;
               o_retire   = 1'b1;
            end
         end
         S_WB: begin
            o_reg_write = 1'b1;
            o_pc_write  = 1'b1;
            o_retire    = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef SEQ_PERF_CNT_EN
   // -------------------------------------------------------------------------
   // Performance counters; both wrap naturally at 32 bits.
   // -------------------------------------------------------------------------
   logic [31:0] r_cycle_count;
   logic [31:0] r_instret_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cycle_count   <= '0;
         r_instret_count <= '0;
      end else begin
         if (r_state != S_IDLE && r_state != S_TRAP)
            r_cycle_count <= r_cycle_count + 32'd1;
         if (o_retire)
            r_instret_count <= r_instret_count + 32'd1;
      end
   end

   assign o_cycle_count   = r_cycle_count;
   assign o_instret_count = r_instret_count;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Instruction-level reference: each instruction is described by its class,
// ack delays and the run level at completion, and the expected per-cycle
// output trace is built from the phase rules. Inputs that must be ignored in
// a given phase are randomized. Directed episodes pin latencies, trap causes
// and reset behaviour with literal values.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

   localparam int T = 15;

   typedef struct packed {
      logic run, imem_ack, dmem_ack, br, mw, rw, m2r, ill, az, trap_clr;
   } in_t;

   typedef struct packed {
      logic imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write;
      logic pc_sel, retire, halted, trap;
      logic [1:0] cause;
   } out_t;

   typedef enum int {C_ALU, C_ALUNW, C_BR, C_LD, C_ST, C_ILL} cls_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
   logic       br_en = 1'b0, mw_en = 1'b0, rw_en = 1'b0, m2r = 1'b0, ill = 1'b0;
   logic       alu_zero = 1'b0, trap_clr = 1'b0;
   logic       imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write;
   logic       pc_sel_branch, retire, halted, trap;
   logic [1:0] trap_cause;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_count, instret_count;
`endif

   multicycle_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_run              (run),
      .o_imem_req         (imem_req),
      .i_imem_ack         (imem_ack),
      .o_ir_write         (ir_write),
      .i_branch_enable    (br_en),
      .i_mem_write_enable (mw_en),
      .i_reg_write_enable (rw_en),
      .i_mem_to_reg       (m2r),
      .i_ill_instr        (ill),
      .i_alu_zero         (alu_zero),
      .o_dmem_req         (dmem_req),
      .o_dmem_we          (dmem_we),
      .i_dmem_ack         (dmem_ack),
      .o_reg_write        (reg_write),
      .o_pc_write         (pc_write),
      .o_pc_sel_branch    (pc_sel_branch),
      .o_retire           (retire),
      .o_halted           (halted),
      .o_trap             (trap),
      .o_trap_cause       (trap_cause),
      .i_trap_clr         (trap_clr)
`ifdef SEQ_PERF_CNT_EN
      ,
      .o_cycle_count      (cycle_count),
      .o_instret_count    (instret_count)
`endif
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   out_t obs;
   int   where = 0;            // 0 idle, 1 about to fetch, 2 trapped
   logic [1:0] cur_cause = 2'b00;

   // per-episode observations of the DUT, indexed from the first FETCH cycle
   int ep_cnt, ep_retire_at, ep_irw_at, ep_regw_at, ep_pcsel;
   int ep_dreq, ep_dwe, ep_ireq, ep_pcw;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic in_t rnd();
      in_t r;
      r = 10'($urandom);
      return r;
   endfunction

   function automatic in_t hold(in_t b);
      in_t r;
      r = rnd();
      r.br  = b.br;
      r.mw  = b.mw;
      r.rw  = b.rw;
      r.m2r = b.m2r;
      r.ill = b.ill;
      return r;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.imem_req  = imem_req;
      o.ir_write  = ir_write;
      o.dmem_req  = dmem_req;
      o.dmem_we   = dmem_we;
      o.reg_write = reg_write;
      o.pc_write  = pc_write;
      o.pc_sel    = pc_sel_branch;
      o.retire    = retire;
      o.halted    = halted;
      o.trap      = trap;
      o.cause     = trap_cause;
      return o;
   endfunction

   // One clock cycle: drive inputs after the edge, compare at the falling edge.
   task automatic cyc(input in_t vi, input out_t ve, input string tag);
      @(posedge clk);
      #1;
      run      = vi.run;
      imem_ack = vi.imem_ack;
      dmem_ack = vi.dmem_ack;
      br_en    = vi.br;
      mw_en    = vi.mw;
      rw_en    = vi.rw;
      m2r      = vi.m2r;
      ill      = vi.ill;
      alu_zero = vi.az;
      trap_clr = vi.trap_clr;
      @(negedge clk);
      obs = sample();
      ep_cnt++;
      if (obs.retire && ep_retire_at == 0) begin
         ep_retire_at = ep_cnt;
         ep_pcsel     = int'(obs.pc_sel);
      end
      if (obs.ir_write && ep_irw_at == 0)   ep_irw_at = ep_cnt;
      if (obs.reg_write && ep_regw_at == 0) ep_regw_at = ep_cnt;
      if (obs.dmem_req) ep_dreq++;
      if (obs.dmem_we)  ep_dwe++;
      if (obs.imem_req) ep_ireq++;
      if (obs.pc_write) ep_pcw++;
      n_vec++;
      if (obs !== ve) begin
         n_err++;
         $display("FAIL cycle %s @%0t: got %b, expected %b", tag, $time, obs, ve);
      end
   endtask

   task automatic leave_trap(input int trap_n);
      in_t  vi;
      out_t ve;
      ve = '0;
      ve.trap  = 1'b1;
      ve.cause = cur_cause;
      for (int i = 0; i <= trap_n; i++) begin
         vi = rnd();
         vi.trap_clr = (i == trap_n);
         cyc(vi, ve, "trap");
      end
      cur_cause = 2'b00;
      where = 0;
   endtask

   task automatic leave_idle(input int idle_n);
      in_t  vi;
      out_t ve;
      ve = '0;
      ve.halted = 1'b1;
      for (int i = 0; i <= idle_n; i++) begin
         vi = rnd();
         vi.run = (i == idle_n);
         cyc(vi, ve, "idle");
      end
      where = 1;
   endtask

   task automatic episode(input cls_t c, input int idel, input bit ito,
                          input int ddel, input bit dto, input bit rfin,
                          input bit az, input int idle_n, input int trap_n);
      in_t  vi, base;
      out_t ve;
      int   nf, nm;
      bit   ack;
      if (where == 2) leave_trap(trap_n);
      if (where == 0) leave_idle(idle_n);
      ep_cnt = 0; ep_retire_at = 0; ep_irw_at = 0; ep_regw_at = 0; ep_pcsel = 0;
      ep_dreq = 0; ep_dwe = 0; ep_ireq = 0; ep_pcw = 0;

      // FETCH
      nf = ito ? T : idel + 1;
      for (int i = 1; i <= nf; i++) begin
         vi = rnd();
         vi.imem_ack = !ito && (i == nf);
         ve = '0;
         ve.imem_req = 1'b1;
         ve.ir_write = vi.imem_ack;
         cyc(vi, ve, "fetch");
      end
      if (ito) begin
         where = 2;
         cur_cause = 2'b01;
         return;
      end

      // decoded instruction bits, held until completion
      base = rnd();
      base.ill = 1'b0;
      case (c)
         C_ALU:   begin base.br = 0; base.mw = 0; base.m2r = 0; base.rw = 1; end
         C_ALUNW: begin base.br = 0; base.mw = 0; base.m2r = 0; base.rw = 0; end
         C_BR:    begin base.br = 1; end
         C_LD:    begin base.br = 0; base.mw = 0; base.m2r = 1; end
         C_ST:    begin base.br = 0; base.mw = 1; base.m2r = 0; end
         default: begin base.ill = 1; end
      endcase

      // DECODE
      vi = hold(base);
      ve = '0;
      cyc(vi, ve, "decode");
      if (c == C_ILL) begin
         where = 2;
         cur_cause = 2'b10;
         return;
      end

      // EXECUTE
      vi = hold(base);
      vi.az = az;
      ve = '0;
      if (c == C_BR || c == C_ALUNW) begin
         vi.run      = rfin;
         ve.pc_write = 1'b1;
         ve.retire   = 1'b1;
         ve.pc_sel   = (c == C_BR) ? az : 1'b0;
      end
      cyc(vi, ve, "execute");
      if (c == C_BR || c == C_ALUNW) begin
         where = rfin ? 1 : 0;
         return;
      end

      // MEM
      if (c == C_LD || c == C_ST) begin
         nm = dto ? T : ddel + 1;
         for (int i = 1; i <= nm; i++) begin
            vi = hold(base);
            ack = !dto && (i == nm);
            vi.dmem_ack = ack;
            ve = '0;
            ve.dmem_req = 1'b1;
            ve.dmem_we  = (c == C_ST);
            if (ack && c == C_ST) begin
               vi.run      = rfin;
               ve.pc_write = 1'b1;
               ve.retire   = 1'b1;
            end
            cyc(vi, ve, "mem");
         end
         if (dto) begin
            where = 2;
            cur_cause = 2'b11;
            return;
         end
         if (c == C_ST) begin
            where = rfin ? 1 : 0;
            return;
         end
      end

      // WB
      vi = hold(base);
      vi.run = rfin;
      ve = '0;
      ve.reg_write = 1'b1;
      ve.pc_write  = 1'b1;
      ve.retire    = 1'b1;
      cyc(vi, ve, "wb");
      where = rfin ? 1 : 0;
   endtask

   initial begin
      in_t  vi;
      out_t ve;
      cls_t c;
      int   idel, ddel;

      // reset state
      repeat (2) @(negedge clk);
      obs = sample();
      chk("reset_halted", int'(obs.halted), 1);
      chk("reset_imem_req", int'(obs.imem_req), 0);
      chk("reset_trap", int'(obs.trap), 0);
      chk("reset_cause", int'(obs.cause), 0);
      rst_n = 1'b1;

      // ADD: ir_write in cycle 1, retire with reg_write in cycle 4
      episode(C_ALU, 0, 0, 0, 0, 1, 0, 1, 0);
      chk("add_irw_at", ep_irw_at, 1);
      chk("add_retire_at", ep_retire_at, 4);
      chk("add_regw_at", ep_regw_at, 4);
      chk("add_pcsel", ep_pcsel, 0);

      // BEQ taken / not taken
      episode(C_BR, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("beq1_retire_at", ep_retire_at, 3);
      chk("beq1_pcsel", ep_pcsel, 1);
      chk("beq1_no_regw", ep_regw_at, 0);
      episode(C_BR, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("beq0_retire_at", ep_retire_at, 3);
      chk("beq0_pcsel", ep_pcsel, 0);
      chk("beq0_no_regw", ep_regw_at, 0);

      // LW with dmem_ack delayed 3 cycles
      episode(C_LD, 0, 0, 3, 0, 1, 0, 0, 0);
      chk("lw_dreq_cycles", ep_dreq, 4);
      chk("lw_dwe_cycles", ep_dwe, 0);
      chk("lw_retire_at", ep_retire_at, 8);
      chk("lw_regw_at", ep_regw_at, 8);

      // SW with run low at completion -> halted next cycle
      episode(C_ST, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("sw_retire_at", ep_retire_at, 5);
      leave_idle(0);
      chk("sw_halted_next", int'(obs.halted), 1);

      // imem ack in the last allowed cycle still wins
      episode(C_ALU, T - 1, 0, 0, 0, 1, 0, 0, 0);
      chk("ack_boundary_retire_at", ep_retire_at, T + 3);

      // imem timeout
      episode(C_ALU, 0, 1, 0, 0, 1, 0, 0, 0);
      chk("imem_to_req_cycles", ep_ireq, 15);
      leave_trap(2);
      chk("imem_to_trap", int'(obs.trap), 1);
      chk("imem_to_cause", int'(obs.cause), 1);
      leave_idle(0);
      chk("trap_clr_halted", int'(obs.halted), 1);
      chk("trap_clr_cause", int'(obs.cause), 0);

      // illegal instruction
      episode(C_ILL, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("ill_no_pcw", ep_pcw, 0);
      leave_trap(0);
      chk("ill_cause", int'(obs.cause), 2);

      // store timeout
      episode(C_ST, 0, 0, 0, 1, 1, 0, 0, 0);
      chk("sw_to_dwe_cycles", ep_dwe, 15);
      leave_trap(1);
      chk("sw_to_cause", int'(obs.cause), 3);

      // reset during FETCH
      leave_idle(0);
      vi = rnd();
      vi.imem_ack = 1'b0;
      ve = '0;
      ve.imem_req = 1'b1;
      cyc(vi, ve, "rst_fetch");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      run = 1'b0;
      imem_ack = 1'b0;
      #1;
      chk("rst_drops_imem_req", int'(imem_req), 0);
      chk("rst_halted", int'(halted), 1);
      @(negedge clk);
      rst_n = 1'b1;
      where = 0;
      cur_cause = 2'b00;

      // randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         c    = cls_t'($urandom_range(0, 5));
         idel = ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
         ddel = ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
         episode(c, idel, ($urandom_range(0, 19) == 0), ddel,
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
